// File: rtl/hms_display_driver.sv
// hms_display_driver: scans binary HH:MM:SS onto a 6-digit common-anode seven-segment display, marking the edit digit.
// Optional HMS_BLINK_EN blinks the selected digit instead of lighting its decimal point.
module hms_display_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [5:0] hour_i,
  input  logic [2:0] digitp_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  localparam int SW = $clog2(SCAN_DIV);
  logic [SW-1:0] scan_cnt;
  logic [2:0] idx;
  logic [5:0] sec_s, min_s, hour_s, sec_v, min_v, hour_v, v;
  logic [3:0] d;
  logic [6:0] font;
  logic cap, scan_wrap, sel, blank, dp_next;
  assign cap = idx == 3'd0 && scan_cnt == '0;
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  // the frame-start cycle shows the values being captured, not the stale snapshot
  assign sec_v = cap ? sec_i : sec_s;
  assign min_v = cap ? min_i : min_s;
  assign hour_v = cap ? hour_i : hour_s;
  assign sel = digitp_i == idx;
  always_comb begin
    v = idx[2] ? hour_v : idx[1] ? min_v : sec_v;
    d = idx[0] ? 4'(v / 6'd10) : 4'(v % 6'd10);
    case (d)
      4'd0: font = 7'b1000000;
      4'd1: font = 7'b1111001;
      4'd2: font = 7'b0100100;
      4'd3: font = 7'b0110000;
      4'd4: font = 7'b0011001;
      4'd5: font = 7'b0010010;
      4'd6: font = 7'b0000010;
      4'd7: font = 7'b1111000;
      4'd8: font = 7'b0000000;
      default: font = 7'b0010000;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scan_cnt <= '0;
      idx <= 3'd0;
      sec_s <= 6'd0;
      min_s <= 6'd0;
      hour_s <= 6'd0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      if (cap) begin
        sec_s <= sec_i;
        min_s <= min_i;
        hour_s <= hour_i;
      end
    end
  end
`ifdef HMS_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_cnt;
  logic blink_on, changed;
  logic [2:0] digitp_q;
  assign changed = digitp_i != digitp_q;
  // a cursor move shows the newly selected digit immediately
  assign blank = sel && !blink_on && !changed;
  assign dp_next = 1'b1;
  always_ff @(posedge clk_i) digitp_q <= digitp_i;
  always_ff @(posedge clk_i) begin
    if (reset_i || changed) begin
      blink_cnt <= '0;
      blink_on <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
      if (blink_cnt == BW'(BLINK_DIV - 1)) blink_on <= ~blink_on;
    end
  end
`else
  assign blank = 1'b0;
  assign dp_next = !sel;
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      an_o <= 6'h3F;
      seg_o <= 7'h7F;
      dp_o <= 1'b1;
    end else begin
      an_o <= ~(6'd1 << idx);
      seg_o <= blank ? 7'h7F : font;
      dp_o <= dp_next;
    end
  end
endmodule

// File: tb/tb_hms_display_driver.sv
// tb_hms_display_driver: reference model of the display scan checked every cycle, plus literal checks pinning the model.
module tb_hms_display_driver;
  localparam int SD = 2;
  localparam int BD = 4;
  logic clk = 0, reset = 1;
  logic [5:0] sec = 0, mn = 0, hr = 0;
  logic [2:0] dpi = 3'd7;
  logic [5:0] an;
  logic [6:0] seg;
  logic dp;
  int checks = 0, fails = 0;
  int font_t [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
  int lan [6] = '{'h3E, 'h3D, 'h3B, 'h37, 'h2F, 'h1F};
  int lseg [6] = '{'h12, 'h19, 'h78, 'h40, 'h30, 'h79};
  bit valid = 0;
  int n = 0, k = 0, s_sec = 0, s_min = 0, s_hr = 0;
  logic [2:0] prev = 3'd7;

  always #5 clk = ~clk;

  hms_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_i(clk), .reset_i(reset), .sec_i(sec), .min_i(mn), .hour_i(hr),
    .digitp_i(dpi), .an_o(an), .seg_o(seg), .dp_o(dp)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // n counts clocks since reset released; k counts clocks since reset or the last cursor move
  always @(posedge clk) begin
    int e_an, e_seg, e_dp, ix, v, d;
    bit vis;
    if (reset) begin
      e_an = 'h3F; e_seg = 'h7F; e_dp = 1; n = 0; k = 0; valid = 1;
    end else begin
      if (n % (6 * SD) == 0) begin s_sec = sec; s_min = mn; s_hr = hr; end
      ix = (n / SD) % 6;
      v = ix < 2 ? s_sec : ix < 4 ? s_min : s_hr;
      d = ix % 2 ? v / 10 : v % 10;
      e_an = 'h3F & ~(1 << ix);
      e_seg = font_t[d];
      if (dpi != prev) k = 0;
`ifdef HMS_BLINK_EN
      vis = k == 0 || ((k - 1) / BD) % 2 == 0;
      if (int'(dpi) == ix && !vis) e_seg = 'h7F;
      e_dp = 1;
`else
      vis = 1;
      e_dp = int'(dpi) == ix ? 0 : 1;
`endif
      n++;
    end
    k++;
    prev = dpi;
    if (valid) begin
      #2;
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", an, 'h3F);
    chk("reset_seg", seg, 'h7F);
    chk("reset_dp", dp, 1);
    sec = 45; mn = 7; hr = 13; dpi = 7; reset = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("frame_an", an, lan[i / 2]);
      chk("frame_seg", seg, lseg[i / 2]);
      chk("frame_dp", dp, 1);
    end
    hr = 63; mn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 10) chk("hour63_tens", seg, 'h02);
      if (i == 8) chk("hour63_ones", seg, 'h30);
      if (i == 4) chk("min0_ones", seg, 'h40);
    end
    repeat (9) @(negedge clk);
    chk("pre_reset_an", an, 'h2F);
    reset = 1;
    @(negedge clk);
    chk("midreset_an", an, 'h3F);
    chk("midreset_seg", seg, 'h7F);
    reset = 0;
    @(negedge clk);
    chk("restart_an", an, 'h3E);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) sec = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) mn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 29) == 0) hr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) dpi = 3'($urandom_range(0, 7));
      reset = $urandom_range(0, 199) == 0;
      @(negedge clk);
    end
    reset = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
